// File: rtl/event_sink_if.sv
// Valid/ready channel carrying the ID of a pending event
// from event_sink to its consumer.
interface event_sink_if #(
  parameter int ID_W = 1
);
  logic            out_valid;
  logic [ID_W-1:0] out_id;
  logic            out_ready;

  modport master (
    output out_valid,
    output out_id,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_id,
    output out_ready
  );
endinterface

// File: rtl/event_sink.sv
// Per-channel event counter/flags with a round-robin arbitrated
// valid/ready queue of pending event IDs.
module event_sink #(
  parameter int NUM_EV = 2,
  parameter int CNT_W  = 32,
  parameter int ID_W   = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_EV-1:0]       ev_trig,
  input  logic [NUM_EV-1:0]       clr,
  output logic [NUM_EV*CNT_W-1:0] ev_count,
  output logic [NUM_EV-1:0]       ev_seen,
  output logic [NUM_EV-1:0]       ev_ovf,
  event_sink_if.master            ev_out
);

  typedef enum logic {
    IDLE,
    PRESENT
  } state_t;

  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt [NUM_EV];
  logic [NUM_EV-1:0] r_seen;
  logic [NUM_EV-1:0] r_ovf;
  logic [NUM_EV-1:0] r_pend;
  logic [ID_W-1:0]   r_id;
  logic [ID_W-1:0]   r_rr;

  logic              w_acc;
  logic [NUM_EV-1:0] w_acc_vec;
  logic [NUM_EV-1:0] w_pend_n;
  logic [ID_W-1:0]   w_rr_n;
  logic [ID_W-1:0]   w_pick;
  logic              w_any;
  int                w_dist;
  int                w_best;

  assign w_acc = (r_state == PRESENT) & ev_out.out_ready;

  always_comb begin
    w_acc_vec = '0;
    for (int i = 0; i < NUM_EV; i++) begin
      w_acc_vec[i] = w_acc & (r_id == ID_W'(i));
    end
  end

  // A trigger on the channel being accepted re-arms it.
  assign w_pend_n = (r_pend & ~w_acc_vec) | ev_trig;
  assign w_any    = |w_pend_n;

  always_comb begin
    w_rr_n = r_rr;
    if (w_acc) begin
      if (r_id == ID_W'(NUM_EV - 1)) begin
        w_rr_n = '0;
      end else begin
        w_rr_n = r_id + ID_W'(1);
      end
    end
  end

  // Pick the pending channel closest to the pointer, wrapping.
  always_comb begin
    w_pick = '0;
    w_best = NUM_EV;
    w_dist = 0;
    for (int i = 0; i < NUM_EV; i++) begin
      if (i >= int'(w_rr_n)) begin
        w_dist = i - int'(w_rr_n);
      end else begin
        w_dist = i + NUM_EV - int'(w_rr_n);
      end
      if (w_pend_n[i] && (w_dist < w_best)) begin
        w_best = w_dist;
        w_pick = ID_W'(i);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend <= '0;
      r_seen <= '0;
      r_ovf  <= '0;
      for (int i = 0; i < NUM_EV; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      r_pend <= w_pend_n;
      for (int i = 0; i < NUM_EV; i++) begin
        if (clr[i]) begin
          r_cnt[i]  <= CNT_W'(ev_trig[i]);
          r_seen[i] <= ev_trig[i];
          r_ovf[i]  <= 1'b0;
        end else if (ev_trig[i]) begin
          r_cnt[i]  <= r_cnt[i] + CNT_W'(1);
          r_seen[i] <= 1'b1;
          if (r_pend[i] & ~w_acc_vec[i]) begin
            r_ovf[i] <= 1'b1;
          end
        end
      end
    end
  end

  // While stalled the presented ID is frozen; otherwise
  // the next choice is taken from the updated pending set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_id    <= '0;
      r_rr    <= '0;
    end else begin
      r_rr <= w_rr_n;
      unique case (r_state)
        IDLE: begin
          if (w_any) begin
            r_state <= PRESENT;
            r_id    <= w_pick;
          end
        end
        PRESENT: begin
          if (w_acc) begin
            if (w_any) begin
              r_id <= w_pick;
            end else begin
              r_state <= IDLE;
            end
          end
        end
      endcase
    end
  end

  for (genvar g = 0; g < NUM_EV; g++) begin : g_cnt
    assign ev_count[g*CNT_W +: CNT_W] = r_cnt[g];
  end

  assign ev_seen          = r_seen;
  assign ev_ovf           = r_ovf;
  assign ev_out.out_valid = (r_state == PRESENT);
  assign ev_out.out_id    = r_id;

endmodule

// File: tb/tb_event_sink.sv
// Directed bench for event_sink: expected accepted IDs are queued
// as stimulus is driven and checked when each handshake fires.
module tb_event_sink;
  localparam int NEV = 2;
  localparam int CW  = 4;
  localparam int IW  = 1;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NEV-1:0]    ev_trig;
  logic [NEV-1:0]    clr;
  logic [NEV*CW-1:0] ev_count;
  logic [NEV-1:0]    ev_seen;
  logic [NEV-1:0]    ev_ovf;

  int errors = 0;
  int checks = 0;
  logic [IW-1:0] exp_q[$];

  event_sink_if #(.ID_W(IW)) sink();

  event_sink #(
    .NUM_EV(NEV),
    .CNT_W (CW),
    .ID_W  (IW)
  ) u_dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ev_trig (ev_trig),
    .clr     (clr),
    .ev_count(ev_count),
    .ev_seen (ev_seen),
    .ev_ovf  (ev_ovf),
    .ev_out  (sink.master)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: scoreboard check at negedge, return 1 after posedge.
  task automatic cyc();
    logic [IW-1:0] e;
    @(negedge clk);
    if (rst_n && sink.out_valid && sink.out_ready) begin
      checks++;
      assert (exp_q.size() != 0) else begin
        errors++;
        $error("FAIL sb_extra: observed id %0d expected none",
               sink.out_id);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        assert (sink.out_id === e) else begin
          errors++;
          $error("FAIL sb_id: observed %0d expected %0d",
                 sink.out_id, e);
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    ev_trig = '0;
    clr = '0;
    sink.out_ready = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rst_valid", 32'(sink.out_valid), 32'h0);
    chk("rst_id", 32'(sink.out_id), 32'h0);
    chk("rst_count", 32'(ev_count), 32'h0);
    chk("rst_seen", 32'(ev_seen), 32'h0);
    chk("rst_ovf", 32'(ev_ovf), 32'h0);
    rst_n = 1'b1;
    cyc();

    // single event on channel 0
    ev_trig = 2'b01;
    cyc();
    ev_trig = 2'b00;
    chk("t1_cnt0", 32'(ev_count[3:0]), 32'h1);
    chk("t1_seen", 32'(ev_seen), 32'h1);
    chk("t1_valid", 32'(sink.out_valid), 32'h1);
    chk("t1_id", 32'(sink.out_id), 32'h0);
    exp_q.push_back(1'b0);
    sink.out_ready = 1'b1;
    cyc();
    chk("t1_drop", 32'(sink.out_valid), 32'h0);

    // channel 1, then channel 0 again
    ev_trig = 2'b10;
    exp_q.push_back(1'b1);
    cyc();
    ev_trig = 2'b00;
    chk("t2_seen", 32'(ev_seen), 32'h3);
    chk("t2_cnt1", 32'(ev_count[7:4]), 32'h1);
    chk("t2_id", 32'(sink.out_id), 32'h1);
    cyc();
    ev_trig = 2'b01;
    exp_q.push_back(1'b0);
    cyc();
    ev_trig = 2'b00;
    cyc();
    chk("t2_cnt0", 32'(ev_count[3:0]), 32'h2);
    chk("t2_idle", 32'(sink.out_valid), 32'h0);

    // both at once, pointer at 1: order 1 then 0
    ev_trig = 2'b11;
    exp_q.push_back(1'b1);
    exp_q.push_back(1'b0);
    cyc();
    ev_trig = 2'b00;
    chk("t3a_first", 32'(sink.out_id), 32'h1);
    cyc();
    chk("t3a_second", 32'(sink.out_id), 32'h0);
    chk("t3a_valid", 32'(sink.out_valid), 32'h1);
    cyc();
    chk("t3a_idle", 32'(sink.out_valid), 32'h0);
    // move pointer to 0, then both at once: order 0 then 1
    ev_trig = 2'b10;
    exp_q.push_back(1'b1);
    cyc();
    ev_trig = 2'b00;
    cyc();
    ev_trig = 2'b11;
    exp_q.push_back(1'b0);
    exp_q.push_back(1'b1);
    cyc();
    ev_trig = 2'b00;
    chk("t3b_first", 32'(sink.out_id), 32'h0);
    cyc();
    chk("t3b_second", 32'(sink.out_id), 32'h1);
    cyc();
    chk("t3b_idle", 32'(sink.out_valid), 32'h0);

    // accept a channel-0 event so the pointer sits at 1, then clear
    ev_trig = 2'b01;
    exp_q.push_back(1'b0);
    cyc();
    ev_trig = 2'b00;
    cyc();
    clr = 2'b11;
    cyc();
    clr = 2'b00;
    chk("clr_count", 32'(ev_count), 32'h0);
    chk("clr_seen", 32'(ev_seen), 32'h0);

    // overflow while stalled; hold rule with channel 1 favoured
    sink.out_ready = 1'b0;
    ev_trig = 2'b01;
    cyc();
    cyc();
    ev_trig = 2'b10;
    cyc();
    ev_trig = 2'b00;
    chk("t4_ovf", 32'(ev_ovf), 32'h1);
    chk("t4_cnt0", 32'(ev_count[3:0]), 32'h2);
    chk("t4_cnt1", 32'(ev_count[7:4]), 32'h1);
    chk("t4_valid", 32'(sink.out_valid), 32'h1);
    chk("t4_hold", 32'(sink.out_id), 32'h0);
    cyc();
    chk("t4_hold2", 32'(sink.out_id), 32'h0);
    exp_q.push_back(1'b0);
    exp_q.push_back(1'b1);
    sink.out_ready = 1'b1;
    cyc();
    chk("t4_next", 32'(sink.out_id), 32'h1);
    cyc();
    chk("t4_idle", 32'(sink.out_valid), 32'h0);
    chk("t4_ovf_sticky", 32'(ev_ovf), 32'h1);

    // wrap: level held 15 cycles, accepted every cycle, no overflow
    clr = 2'b01;
    cyc();
    clr = 2'b00;
    chk("t5_clr", 32'(ev_count[3:0]), 32'h0);
    chk("t5_clr_ovf", 32'(ev_ovf), 32'h0);
    for (int i = 0; i < 15; i++) exp_q.push_back(1'b0);
    ev_trig = 2'b01;
    repeat (15) cyc();
    ev_trig = 2'b00;
    cyc();
    chk("t5_max", 32'(ev_count[3:0]), 32'hF);
    chk("t5_no_ovf", 32'(ev_ovf), 32'h0);
    chk("t5_idle", 32'(sink.out_valid), 32'h0);
    exp_q.push_back(1'b0);
    ev_trig = 2'b01;
    cyc();
    ev_trig = 2'b00;
    chk("t5_wrap", 32'(ev_count[3:0]), 32'h0);
    chk("t5_seen", 32'(ev_seen), 32'h3);
    cyc();

    // clear and trigger together on an overflowed pending channel
    sink.out_ready = 1'b0;
    ev_trig = 2'b01;
    cyc();
    cyc();
    chk("t5_ovf_set", 32'(ev_ovf), 32'h1);
    clr = 2'b01;
    cyc();
    clr = 2'b00;
    ev_trig = 2'b00;
    chk("t5_clrtrig_cnt", 32'(ev_count[3:0]), 32'h1);
    chk("t5_clrtrig_ovf", 32'(ev_ovf), 32'h0);
    chk("t5_clrtrig_seen", 32'(ev_seen), 32'h3);
    exp_q.push_back(1'b0);
    sink.out_ready = 1'b1;
    cyc();
    chk("t5_idle2", 32'(sink.out_valid), 32'h0);

    // reset mid-stream with both channels pending
    sink.out_ready = 1'b0;
    ev_trig = 2'b11;
    cyc();
    ev_trig = 2'b00;
    chk("t6_valid", 32'(sink.out_valid), 32'h1);
    rst_n = 1'b0;
    #2;
    chk("t6_rst_valid", 32'(sink.out_valid), 32'h0);
    chk("t6_rst_id", 32'(sink.out_id), 32'h0);
    chk("t6_rst_count", 32'(ev_count), 32'h0);
    chk("t6_rst_seen", 32'(ev_seen), 32'h0);
    chk("t6_rst_ovf", 32'(ev_ovf), 32'h0);
    cyc();
    rst_n = 1'b1;
    sink.out_ready = 1'b1;
    repeat (3) cyc();
    chk("t6_no_ghost", 32'(sink.out_valid), 32'h0);
    chk("sb_drain", 32'(exp_q.size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
